// File: rtl/data_mem_ctrl_if.sv
// Processor data port plus RAM port of the data-memory controller.
// The controller takes the slave view; the processor/RAM side takes the master view.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              ReadData;
  logic              WriteData;
  logic [15:0]       DataAddr;
  logic [DATA_W-1:0] DataOut;
  logic [DATA_W-1:0] DataIn;
  logic              DataDone;
  logic              Err;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemWren;
  logic [DATA_W-1:0] MemQ;

  modport slave (
    input  ReadData, WriteData, DataAddr, DataOut, MemQ,
    output DataIn, DataDone, Err, MemAddr, MemWData, MemWren
  );

  modport master (
    output ReadData, WriteData, DataAddr, DataOut, MemQ,
    input  DataIn, DataDone, Err, MemAddr, MemWData, MemWren
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: one request at a time, LATENCY wait
// cycles before the RAM access, registered read data and DataDone handshake.
module data_mem_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 5
) (
  input  logic            Clock,
  input  logic            Reset,
  data_mem_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, CAPTURE} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              wren_q, wren_d;

  if (ADDR_W < 16) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.DataAddr[15:ADDR_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ReadData || bus.WriteData) begin
          // A read+write conflict is executed as a write and flagged.
          wr_d    = bus.WriteData;
          err_d   = err_q | (bus.ReadData & bus.WriteData);
          addr_d  = bus.DataAddr[ADDR_W-1:0];
          wdata_d = bus.DataOut;
          cnt_d   = LAT;
          state_d = (LAT != 4'd0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ACCESS;
      end
      ACCESS:  state_d = wr_q ? IDLE : CAPTURE;
      CAPTURE: begin
        rdata_d = bus.MemQ;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs come straight from flops so they cannot glitch.
    done_d = (state_d == IDLE);
    wren_d = (state_d == ACCESS) && wr_d;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b1;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
      wren_q  <= wren_d;
    end
  end

  assign bus.DataIn   = rdata_q;
  assign bus.DataDone = done_q;
  assign bus.Err      = err_q;
  assign bus.MemAddr  = addr_q;
  assign bus.MemWData = wdata_q;
  assign bus.MemWren  = wren_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (LATENCY 0 and 5), each with a RAM and
// a transaction-level reference model compared on every falling clock edge.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [1:0]       rst_a = 2'b00;
  logic [1:0]       rd_a  = '0;
  logic [1:0]       wr_a  = '0;
  logic [1:0][15:0] addr_a = '0;
  logic [1:0][15:0] dout_a = '0;
  logic [1:0]       done_a;
  logic [1:0]       err_a;
  logic [1:0][15:0] din_a;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : 5;

    data_mem_ctrl_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    data_mem_ctrl #(.ADDR_W(12), .DATA_W(16), .LATENCY(L)) u_dut (
      .Clock (clk),
      .Reset (rst_a[g]),
      .bus   (bus.slave)
    );

    assign bus.ReadData  = rd_a[g];
    assign bus.WriteData = wr_a[g];
    assign bus.DataAddr  = addr_a[g];
    assign bus.DataOut   = dout_a[g];
    assign done_a[g]     = bus.DataDone;
    assign err_a[g]      = bus.Err;
    assign din_a[g]      = bus.DataIn;

    // RAM: not reset, read data one clock after the address edge.
    logic [15:0] ram [4096];
    logic [15:0] memq;
    initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 16'h0;
      memq = 16'h0;
    end
    always @(posedge clk) begin
      if (bus.MemWren) ram[bus.MemAddr] <= bus.MemWData;
      memq <= ram[bus.MemAddr];
    end
    assign bus.MemQ = memq;

    // Reference model: a request occupies the port for L+1 (write) or L+2 (read)
    // cycles; the memory update / read-data return happens as the busy time ends.
    int          busy = 0;
    bit          m_wr = 1'b0;
    bit          m_err = 1'b0;
    logic [11:0] m_addr = '0;
    logic [15:0] m_wd = '0;
    logic [15:0] m_din = '0;
    logic [15:0] mm [4096];
    initial for (int i = 0; i < 4096; i++) mm[i] = 16'h0;

    always @(posedge clk or negedge rst_a[g]) begin
      if (!rst_a[g]) begin
        busy = 0; m_wr = 1'b0; m_err = 1'b0;
        m_addr = '0; m_wd = '0; m_din = '0;
      end else if (busy > 0) begin
        if (busy == 1) begin
          if (m_wr) mm[m_addr] = m_wd;
          else      m_din = mm[m_addr];
        end
        busy--;
      end else if (rd_a[g] || wr_a[g]) begin
        m_wr   = wr_a[g];
        m_err  = m_err | (rd_a[g] & wr_a[g]);
        m_addr = addr_a[g][11:0];
        m_wd   = dout_a[g];
        busy   = wr_a[g] ? L + 1 : L + 2;
      end
    end

    int          lo_run = 0, hi_run = 0, last_busy = 0, last_hi = 0, wren_cnt = 0;
    logic [11:0] wren_addr = '0;

    always @(negedge clk) begin
      chk("DataDone", g, 32'(bus.DataDone), 32'(busy == 0));
      chk("MemWren",  g, 32'(bus.MemWren),  32'(m_wr && busy == 1));
      chk("MemAddr",  g, 32'(bus.MemAddr),  32'(m_addr));
      chk("MemWData", g, 32'(bus.MemWData), 32'(m_wd));
      chk("DataIn",   g, 32'(bus.DataIn),   32'(m_din));
      chk("Err",      g, 32'(bus.Err),      32'(m_err));
      if (bus.DataDone) begin
        if (lo_run > 0) last_busy = lo_run;
        lo_run = 0;
        hi_run++;
      end else begin
        if (hi_run > 0) last_hi = hi_run;
        hi_run = 0;
        lo_run++;
      end
      if (bus.MemWren) begin
        wren_cnt++;
        wren_addr = bus.MemAddr;
      end
    end
  end

  task automatic wait_idle(int k);
    int n = 0;
    while (!done_a[k] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_a[k]) begin
      tests++; fails++;
      $display("FAIL timeout[%0d]: DataDone got 0 expected 1", k);
    end
  endtask

  task automatic txn(int k, logic r, logic w, logic [15:0] a, logic [15:0] d);
    wait_idle(k);
    rd_a[k] = r; wr_a[k] = w; addr_a[k] = a; dout_a[k] = d;
    @(posedge clk); #1;
    rd_a[k] = 1'b0; wr_a[k] = 1'b0;
    wait_idle(k);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    int wc;
    int k, x;
    logic [15:0] a;

    repeat (2) @(posedge clk);
    #1;
    rst_a = 2'b11;
    settle();
    chk("rst_done",  1, 32'(done_a[1]), 32'd1);
    chk("rst_wren",  1, 32'(g_dut[1].bus.MemWren), 32'd0);
    chk("rst_din",   1, 32'(din_a[1]), 32'd0);
    chk("rst_err",   1, 32'(err_a[1]), 32'd0);

    txn(1, 1'b0, 1'b1, 16'h0012, 16'hBEEF);
    settle();
    chk("wr_busy",  1, 32'(g_dut[1].last_busy), 32'd6);
    chk("wr_pulse", 1, 32'(g_dut[1].wren_cnt),  32'd1);
    chk("wr_addr",  1, 32'(g_dut[1].wren_addr), 32'h012);

    txn(1, 1'b1, 1'b0, 16'h0012, 16'h0000);
    settle();
    chk("rd_busy", 1, 32'(g_dut[1].last_busy), 32'd7);
    chk("rd_data", 1, 32'(din_a[1]), 32'hBEEF);

    // Back-to-back: request held through the first completion.
    wait_idle(1);
    rd_a[1] = 1'b1; addr_a[1] = 16'h0012;
    @(posedge clk); #1;
    wait_idle(1);
    @(posedge clk); #1;
    rd_a[1] = 1'b0;
    wait_idle(1);
    settle();
    chk("b2b_gap",  1, 32'(g_dut[1].last_hi),   32'd1);
    chk("b2b_busy", 1, 32'(g_dut[1].last_busy), 32'd7);
    chk("b2b_data", 1, 32'(din_a[1]), 32'hBEEF);

    txn(1, 1'b1, 1'b1, 16'h00FF, 16'h1234);
    settle();
    chk("conf_err", 1, 32'(err_a[1]), 32'd1);
    txn(1, 1'b1, 1'b0, 16'h00FF, 16'h0000);
    settle();
    chk("conf_rd",  1, 32'(din_a[1]), 32'h1234);
    chk("conf_err2", 1, 32'(err_a[1]), 32'd1);

    // Abort a write during its wait cycles.
    txn(1, 1'b0, 1'b1, 16'h0020, 16'h1111);
    settle();
    wc = g_dut[1].wren_cnt;
    wait_idle(1);
    wr_a[1] = 1'b1; addr_a[1] = 16'h0020; dout_a[1] = 16'hAAAA;
    @(posedge clk); #1;
    wr_a[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_a[1] = 1'b0;
    @(posedge clk); #1;
    rst_a[1] = 1'b1;
    settle();
    chk("abort_din", 1, 32'(din_a[1]), 32'd0);
    chk("abort_err", 1, 32'(err_a[1]), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_wren", 1, 32'(g_dut[1].wren_cnt), 32'(wc));
    txn(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    settle();
    chk("abort_rd", 1, 32'(din_a[1]), 32'h1111);

    // Aliasing with zero latency.
    txn(0, 1'b0, 1'b1, 16'hF020, 16'h5555);
    settle();
    chk("l0_wr_busy", 0, 32'(g_dut[0].last_busy), 32'd1);
    chk("l0_wr_addr", 0, 32'(g_dut[0].wren_addr), 32'h020);
    txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    settle();
    chk("l0_rd_busy", 0, 32'(g_dut[0].last_busy), 32'd2);
    chk("l0_rd_data", 0, 32'(din_a[0]), 32'h5555);

    // Random traffic on both instances, model checks every cycle.
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 1));
      x = int'($urandom_range(0, 15));
      a = 16'($urandom) & 16'hF01F;
      txn(k, (x == 0) || (x < 8), (x == 0) || (x >= 8), a, 16'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
